// File: rtl/swatt_session_ctrl.sv
// Sequences SW-Att sessions running from SMEM and requests an MCU reset on any session violation.
// Define SWATT_TIMEOUT_EN to add a session timer that kills sessions reaching TIMEOUT cycles.
module swatt_session_ctrl #(
    parameter logic [15:0]      SMEM_BASE     = 16'hE000,
    parameter logic [15:0]      SMEM_SIZE     = 16'h1000,
    parameter logic [15:0]      SMEM_EXIT     = SMEM_BASE + SMEM_SIZE - 16'd2,
    parameter logic [15:0]      RESET_HANDLER = 16'hFFFE,
    parameter int unsigned      CTR_W         = 16,
    parameter int unsigned      TMR_W         = 20,
    parameter logic [TMR_W-1:0] TIMEOUT       = 20'd1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic             irq,
    input  logic             dma_en,
    output logic             kill,
    output logic             in_att,
    output logic             att_done,
    output logic [CTR_W-1:0] att_count
);

    typedef enum logic [1:0] {StIdle, StAtt, StKill} state_e;

    state_e           state_q, state_d;
    logic [15:0]      prev_pc_q;
    logic [CTR_W-1:0] att_count_q, att_count_d;
    logic             att_done_q, att_done_d;
    logic             in_smem;
    logic             timeout_hit;
    logic             violation;

    assign in_smem = (pc >= SMEM_BASE) && (pc <= SMEM_EXIT);

`ifdef SWATT_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q, timer_d;

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1'b1));

    // Held at zero outside a session so entry always starts a fresh count.
    always_comb begin
        timer_d = timer_q;
        if (state_q != StAtt) begin
            timer_d = '0;
        end else if (!violation) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        att_count_d = att_count_q;
        att_done_d  = 1'b0;
        violation   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_smem) begin
                    if (pc == SMEM_BASE && !dma_en) begin
                        state_d = StAtt;
                    end else begin
                        violation = 1'b1;
                        state_d   = StKill;
                    end
                end
            end
            StAtt: begin
                // Leaving SMEM is legal only right after the exit instruction.
                if (!in_smem) begin
                    if (prev_pc_q == SMEM_EXIT) begin
                        state_d    = StIdle;
                        att_done_d = 1'b1;
                        if (att_count_q != {CTR_W{1'b1}}) begin
                            att_count_d = att_count_q + CTR_W'(1);
                        end
                    end else begin
                        violation = 1'b1;
                        state_d   = StKill;
                    end
                end else if (irq || dma_en || timeout_hit) begin
                    violation = 1'b1;
                    state_d   = StKill;
                end
            end
            StKill: begin
                if (pc == RESET_HANDLER) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            prev_pc_q   <= 16'h0000;
            att_count_q <= '0;
            att_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_pc_q   <= pc;
            att_count_q <= att_count_d;
            att_done_q  <= att_done_d;
        end
    end

    assign kill      = violation || (state_q == StKill && pc != RESET_HANDLER);
    assign in_att    = (state_q == StAtt);
    assign att_done  = att_done_q;
    assign att_count = att_count_q;

endmodule
